// File: rtl/mul_div_ctrl_pkg.sv
// Shared codes and helpers for the multiply/divide controller.
// Holds the function codes, the controller state encoding and the iteration count.
// Optional macro MDU_DIV_EN: when defined, DIV/DIVU are accepted; otherwise they are ignored.
package mul_div_ctrl_pkg;

   localparam int FUNCT_BUS    = 6;
   localparam int MDU_ITER_CNT = 32;

   localparam logic [FUNCT_BUS-1:0] FUNCT_MTHI  = 6'h11;
   localparam logic [FUNCT_BUS-1:0] FUNCT_MTLO  = 6'h13;
   localparam logic [FUNCT_BUS-1:0] FUNCT_MULT  = 6'h18;
   localparam logic [FUNCT_BUS-1:0] FUNCT_MULTU = 6'h19;
   localparam logic [FUNCT_BUS-1:0] FUNCT_DIV   = 6'h1A;
   localparam logic [FUNCT_BUS-1:0] FUNCT_DIVU  = 6'h1B;

`ifdef MDU_DIV_EN
   localparam bit DIV_ENABLED = 1'b1;
`else
   localparam bit DIV_ENABLED = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_t;

   function automatic logic is_mul_code(input logic [FUNCT_BUS-1:0] f);
      return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
   endfunction

   function automatic logic is_div_code(input logic [FUNCT_BUS-1:0] f);
      return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
   endfunction

   // Codes that run the 32-step iterative datapath in this build.
   function automatic logic is_iter(input logic [FUNCT_BUS-1:0] f);
      return is_mul_code(f) || (DIV_ENABLED && is_div_code(f));
   endfunction

   function automatic logic is_signed_op(input logic [FUNCT_BUS-1:0] f);
      return (f == FUNCT_MULT) || (f == FUNCT_DIV);
   endfunction

endpackage

// File: rtl/mul_div_ctrl_if.sv
// Pipeline-side bundle of the multiply/divide unit.
// Ports: start/funct/operand_a/operand_b/flush toward the unit; stall_req/busy/done/hi/lo back.
// master = EX stage (drives requests), slave = the unit.
interface mul_div_ctrl_if;
   import mul_div_ctrl_pkg::*;

   logic                 start;
   logic [FUNCT_BUS-1:0] funct;
   logic [31:0]          operand_a;
   logic [31:0]          operand_b;
   logic                 flush;
   logic                 stall_req;
   logic                 busy;
   logic                 done;
   logic [31:0]          hi;
   logic [31:0]          lo;

   modport master (
      output start, funct, operand_a, operand_b, flush,
      input  stall_req, busy, done, hi, lo
   );

   modport slave (
      input  start, funct, operand_a, operand_b, flush,
      output stall_req, busy, done, hi, lo
   );
endinterface

// File: rtl/mul_div_ctrl_mdu_step.sv
// One combinational radix-2 step: shift-add multiply or restoring divide on magnitudes.
// Ports: is_div selects the step, acc_hi/acc_lo is the working pair, mag_b the multiplier/divisor.
// Optional macro MDU_DIV_EN: without it only the multiply step exists.
module mdu_step (
   input  logic        is_div,
   input  logic [31:0] acc_hi,
   input  logic [31:0] acc_lo,
   input  logic [31:0] mag_b,
   output logic [31:0] nxt_hi,
   output logic [31:0] nxt_lo
);
   // Multiply: acc_lo holds the not-yet-consumed multiplier bits (LSB first);
   // the product shifts down into acc_lo as they are consumed.
   logic [32:0] sum;
   assign sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : 33'd0);

`ifdef MDU_DIV_EN
   // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out
   // at the top and quotient bits in at the bottom. remainder < divisor keeps
   // the shifted value below 2^33, so the difference fits in 32 bits.
   logic [32:0] shifted;
   logic [32:0] diff;
   assign shifted = {acc_hi, acc_lo[31]};
   assign diff    = shifted - {1'b0, mag_b};

   always_comb begin
      nxt_hi = sum[32:1];
      nxt_lo = {sum[0], acc_lo[31:1]};
      if (is_div) begin
         if (shifted >= {1'b0, mag_b}) begin
            nxt_hi = diff[31:0];
            nxt_lo = {acc_lo[30:0], 1'b1};
         end else begin
            nxt_hi = shifted[31:0];
            nxt_lo = {acc_lo[30:0], 1'b0};
         end
      end
   end
`else
   logic unused_is_div;
   assign unused_is_div = is_div;
   assign nxt_hi = sum[32:1];
   assign nxt_lo = {sum[0], acc_lo[31:1]};
`endif
endmodule

// File: rtl/mul_div_ctrl.sv
// Iterative MIPS HI/LO multiply/divide controller with MTHI/MTLO writes.
// Latency: start accepted in cycle N -> done pulse and new hi/lo in cycle N+34; MTHI/MTLO next edge.
// Backpressure: stall_req freezes the pipeline from acceptance through FIX; flush aborts, leaving hi/lo.
// Ports: clk, rst (sync, active-high), bus (slave modport). Optional macro MDU_DIV_EN enables DIV/DIVU.
module mul_div_ctrl
   import mul_div_ctrl_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   mul_div_ctrl_if.slave bus
);
   mdu_state_t  state, state_nxt;
   logic [4:0]  cnt;
   logic [31:0] acc_hi, acc_lo, mag_b;
   logic [31:0] step_hi, step_lo;
   logic [31:0] fix_hi, fix_lo;
   logic [31:0] hi_r, lo_r;
   logic [63:0] prod;
   logic        sign_a, sign_b, op_signed, op_div;
   logic        iter_req, accept, new_sa, new_sb;

   assign iter_req = (state == ST_IDLE) && bus.start && is_iter(bus.funct);
   assign accept   = iter_req && !bus.flush;
   assign new_sa   = is_signed_op(bus.funct) && bus.operand_a[31];
   assign new_sb   = is_signed_op(bus.funct) && bus.operand_b[31];

   mdu_step u_step (
      .is_div (op_div),
      .acc_hi (acc_hi),
      .acc_lo (acc_lo),
      .mag_b  (mag_b),
      .nxt_hi (step_hi),
      .nxt_lo (step_lo)
   );

   always_comb begin
      state_nxt     = state;
      bus.stall_req = 1'b0;
      bus.busy      = (state != ST_IDLE);
      bus.done      = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.stall_req = iter_req;
            if (accept) state_nxt = ST_CALC;
         end
         ST_CALC: begin
            bus.stall_req = 1'b1;
            if (cnt == '0) state_nxt = ST_FIX;
         end
         ST_FIX: begin
            bus.stall_req = 1'b1;
            state_nxt     = ST_DONE;
         end
         ST_DONE: begin
            bus.done  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (bus.flush) state_nxt = ST_IDLE;
   end

   // Sign restoration. Divide by zero leaves |a| as remainder, which becomes a
   // again after the dividend sign is applied; only the quotient is forced.
   always_comb begin
      prod   = {acc_hi, acc_lo};
      fix_hi = acc_hi;
      fix_lo = acc_lo;
      if (op_div) begin
         if (op_signed && (sign_a ^ sign_b)) fix_lo = -acc_lo;
         if (op_signed && sign_a)            fix_hi = -acc_hi;
         if (mag_b == '0)                    fix_lo = '1;
      end else begin
         if (op_signed && (sign_a ^ sign_b)) prod = -{acc_hi, acc_lo};
         fix_hi = prod[63:32];
         fix_lo = prod[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         mag_b     <= '0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         op_signed <= 1'b0;
         op_div    <= 1'b0;
         hi_r      <= '0;
         lo_r      <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt       <= 5'(MDU_ITER_CNT - 1);
            sign_a    <= new_sa;
            sign_b    <= new_sb;
            op_signed <= is_signed_op(bus.funct);
            op_div    <= DIV_ENABLED && is_div_code(bus.funct);
            acc_hi    <= '0;
            acc_lo    <= new_sa ? -bus.operand_a : bus.operand_a;
            mag_b     <= new_sb ? -bus.operand_b : bus.operand_b;
         end else if (state == ST_CALC) begin
            cnt    <= cnt - 5'd1;
            acc_hi <= step_hi;
            acc_lo <= step_lo;
         end
         if (state == ST_FIX && !bus.flush) begin
            hi_r <= fix_hi;
            lo_r <= fix_lo;
         end else if (state == ST_IDLE && bus.start && !bus.flush) begin
            if (bus.funct == FUNCT_MTHI) hi_r <= bus.operand_a;
            if (bus.funct == FUNCT_MTLO) lo_r <= bus.operand_a;
         end
      end
   end

   assign bus.hi = hi_r;
   assign bus.lo = lo_r;
endmodule

// File: tb/tb_mul_div_ctrl.sv
// Self-checking bench for mul_div_ctrl: directed cases with literal results plus random traffic.
// A transaction-level model (64-bit arithmetic, cycle age since acceptance) predicts every output.
// Compare process checks busy/done/stall_req/hi/lo each cycle; MDU_DIV_EN selects the divide cases.
module tb_mul_div_ctrl;

   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mul_div_ctrl_if bus ();
   mul_div_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   int n_vec  = 0;
   int n_miss = 0;

   // Model: age 0 = idle, 1..34 = cycles since the accepting edge (34 = done cycle).
   bit          m_valid = 1'b0;
   int          m_age   = 0;
   logic [31:0] m_hi, m_lo, p_hi, p_lo;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic m_iter(input logic [5:0] f);
`ifdef MDU_DIV_EN
      return f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU;
`else
      return f == F_MULT || f == F_MULTU;
`endif
   endfunction

   function automatic logic [63:0] m_result(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sq, sr;
      logic [63:0] r;
      r = '0;
      case (f)
         F_MULT:  r = 64'(longint'($signed(a)) * longint'($signed(b)));
         F_MULTU: r = {32'd0, a} * {32'd0, b};
         F_DIV: begin
            if (b == 0) r = {a, 32'hFFFF_FFFF};
            else begin
               sq = longint'($signed(a)) / longint'($signed(b));
               sr = longint'($signed(a)) % longint'($signed(b));
               r  = {sr[31:0], sq[31:0]};
            end
         end
         F_DIVU: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: r = '0;
      endcase
      return r;
   endfunction

   // Compare process: outputs at negedge, model advanced at posedge.
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            chk("busy", 64'(bus.busy), 64'(m_age != 0));
            chk("done", 64'(bus.done), 64'(m_age == 34));
            chk("stall_req", 64'(bus.stall_req),
                64'((m_age == 0 && bus.start && m_iter(bus.funct)) || (m_age >= 1 && m_age <= 33)));
            chk("hi", 64'(bus.hi), 64'(m_hi));
            chk("lo", 64'(bus.lo), 64'(m_lo));
         end
         @(posedge clk);
         if (rst) begin
            m_valid = 1'b1;
            m_age   = 0;
            m_hi    = '0;
            m_lo    = '0;
         end else if (m_valid) begin
            if (bus.flush) m_age = 0;
            else if (m_age == 0) begin
               if (bus.start && m_iter(bus.funct)) begin
                  m_age = 1;
                  {p_hi, p_lo} = m_result(bus.funct, bus.operand_a, bus.operand_b);
               end else if (bus.start && bus.funct == F_MTHI) m_hi = bus.operand_a;
               else if (bus.start && bus.funct == F_MTLO) m_lo = bus.operand_a;
            end else if (m_age == 34) m_age = 0;
            else begin
               m_age++;
               if (m_age == 34) begin
                  m_hi = p_hi;
                  m_lo = p_lo;
               end
            end
         end
      end
   end

   task automatic drive(input logic st, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic fl);
      bus.start     = st;
      bus.funct     = f;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.flush     = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, wait (bounded) for done; returns cycles from acceptance to done.
   task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int lat);
      drive(1'b1, f, a, b, 1'b0);
      tick();
      drive(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
      lat = 1;
      while (!bus.done && lat < 60) begin
         tick();
         lat++;
      end
   endtask

   task automatic check_op(input string nm, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo);
      int lat;
      run_op(f, a, b, lat);
      chk({nm, " latency"}, 64'(lat), 64'd34);
      chk({nm, " hi"}, 64'(bus.hi), 64'(ehi));
      chk({nm, " lo"}, 64'(bus.lo), 64'(elo));
      chk({nm, " model hi"}, 64'(m_hi), 64'(ehi));
      chk({nm, " model lo"}, 64'(m_lo), 64'(elo));
      tick();
   endtask

   function automatic logic [31:0] pick_opnd();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [5:0] pick_funct();
      case ($urandom_range(0, 7))
         0: return F_MULT;
         1: return F_MULTU;
         2: return F_DIV;
         3: return F_DIVU;
         4: return F_MTHI;
         5: return F_MTLO;
         default: return 6'($urandom_range(0, 63));
      endcase
   endfunction

   initial begin
      drive(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("reset busy", 64'(bus.busy), 64'd0);
      chk("reset done", 64'(bus.done), 64'd0);
      chk("reset stall_req", 64'(bus.stall_req), 64'd0);
      chk("reset hi", 64'(bus.hi), 64'd0);
      chk("reset lo", 64'(bus.lo), 64'd0);
      tick();

      check_op("MULTU max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      check_op("MULT -2x3", F_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
`ifdef MDU_DIV_EN
      check_op("DIV -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      check_op("DIV ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      check_op("DIVU by 0", F_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
      check_op("DIV -9/0", F_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
`else
      drive(1'b1, F_DIVU, 32'd8, 32'd2, 1'b0);
      #1;
      chk("DIVU off stall_req", 64'(bus.stall_req), 64'd0);
      tick();
      drive(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
      tick();
      chk("DIVU off busy", 64'(bus.busy), 64'd0);
      chk("DIVU off done", 64'(bus.done), 64'd0);
      chk("DIVU off hi", 64'(bus.hi), 64'hFFFF_FFFF);
      chk("DIVU off lo", 64'(bus.lo), 64'hFFFF_FFFA);
`endif

      // MTLO, then a multiply flushed at N+10.
      drive(1'b1, F_MTLO, 32'h1234, 32'd0, 1'b0);
      tick();
      drive(1'b1, F_MULTU, 32'd5, 32'd6, 1'b0);
      tick();
      drive(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < 9; i++) tick();
      drive(1'b0, 6'h00, 32'd0, 32'd0, 1'b1);
      tick();
      drive(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
      chk("flush busy", 64'(bus.busy), 64'd0);
      chk("flush lo", 64'(bus.lo), 64'h1234);
      for (int i = 0; i < 30; i++) begin
         chk("flush no done", 64'(bus.done), 64'd0);
         tick();
      end

      // Reset five cycles into a new operation.
      drive(1'b1, F_MULT, 32'd7, 32'd9, 1'b0);
      tick();
      drive(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midop rst busy", 64'(bus.busy), 64'd0);
      chk("midop rst hi", 64'(bus.hi), 64'd0);
      chk("midop rst lo", 64'(bus.lo), 64'd0);
      tick();

      for (int c = 0; c < 9000; c++) begin
         drive(($urandom_range(0, 2) == 0), pick_funct(), pick_opnd(), pick_opnd(),
               ($urandom_range(0, 199) == 0));
         rst = ($urandom_range(0, 2999) == 0);
         if (rst) bus.start = 1'b0;
         tick();
      end
      rst = 1'b0;
      drive(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < 40; i++) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
